tohost_console: RTL and testbench

Downstream consumer of the core's data-memory store port. Watches every store, decodes writes to the tohost word, queues print characters in a small FIFO, and serialises them on an 8N1 UART line. Also latches the poweroff command. Sits beside the data memory in the top level. Replaces ad-hoc queue/UART glue with one verified block.

---
 rtl/tohost_console_pkg.sv | 26 ++
 rtl/tohost_console_if.sv | 9 +
 rtl/tohost_console_fifo.sv | 48 ++++
 rtl/tohost_console.sv | 145 ++++++++++++++
 tb/tb_tohost_console.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tohost_console_pkg.sv
// Shared command codes, TX state encoding and store-decode helpers for the tohost console.
package tohost_console_pkg;

    localparam logic [1:0] TOHOST_CMD_PRINT    = 2'd1;
    localparam logic [1:0] TOHOST_CMD_POWEROFF = 2'd2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic [1:0] cmd;
        logic [7:0] chr;
    } tohost_req_t;

    function automatic tohost_req_t tohost_req(input logic [31:0] wd);
        tohost_req_t r;
        r.cmd = wd[17:16];
        r.chr = wd[7:0];
        return r;
    endfunction

endpackage

// File: rtl/tohost_console_if.sv
// Core data-memory store port as observed by the console: address, byte enables, store data.
interface tohost_console_if;
    logic [31:0] i_d_addr;
    logic [3:0]  i_d_we;
    logic [31:0] i_wd_data;

    modport master (output i_d_addr, output i_d_we, output i_wd_data);
    modport slave  (input  i_d_addr, input  i_d_we, input  i_wd_data);
endinterface

// File: rtl/tohost_console_fifo.sv
// Circular character FIFO; push visible in count the cycle after the edge, head read combinationally.
// Full without a same-cycle pop drops the push and pulses drop_o; no backpressure upstream.
module console_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     w_clk,
    input  logic                     r_rst,
    input  logic                     push_vld_i,
    input  logic [7:0]               push_dat_i,
    input  logic                     pop_i,
    output logic [7:0]               head_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          pop_ok, push_ok;

    assign pop_ok  = pop_i & (count_q != '0);
    // A pop in the same cycle frees the slot the push needs, even when full.
    assign push_ok = push_vld_i & ((count_q < CW'(DEPTH)) | pop_ok);
    assign drop_o  = push_vld_i & ~push_ok;

    always_ff @(posedge w_clk) begin
        if (r_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) tail_q <= tail_q + PW'(1);
            if (pop_ok)  head_q <= head_q + PW'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge w_clk) begin
        if (push_ok) mem_q[tail_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[head_q];
    assign count_o    = count_q;

endmodule

// File: rtl/tohost_console.sv
// Decodes tohost stores (3-cycle pipe to FIFO/poweroff) and serialises queued chars as 8N1 UART.
// Never stalls the core: a print arriving with the FIFO full is dropped and flagged in o_overflow.
module tohost_console
    import tohost_console_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR = 32'h40008000,
    parameter int          QUEUE_DEPTH = 16,
    parameter int          SERIAL_WCNT = 868
) (
    input  logic                          w_clk,
    input  logic                          r_rst,
    tohost_console_if.slave               store_if,
    output logic                          o_txd,
    output logic                          o_poweroff,
    output logic                          o_busy,
    output logic                          o_overflow,
    output logic [$clog2(QUEUE_DEPTH):0]  o_count
);
    localparam int              CNTW       = $clog2(SERIAL_WCNT);
    localparam logic [CNTW-1:0] CNT_RELOAD = CNTW'(SERIAL_WCNT - 1);

    logic        s1_vld_q, s2_vld_q;
    tohost_req_t s1_req_q, s2_req_q;
    logic        poweroff_q, overflow_q;

    logic        push_vld, fifo_drop, pop;
    logic [7:0]  head_dat;
    logic [$clog2(QUEUE_DEPTH):0] fifo_count;

    tx_state_e       state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic            period_done;

    always_ff @(posedge w_clk) begin
        if (r_rst) begin
            s1_vld_q   <= 1'b0;
            s1_req_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_req_q   <= '0;
            poweroff_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            s1_vld_q <= (store_if.i_d_addr == TOHOST_ADDR) && store_if.i_d_we[0];
            s1_req_q <= tohost_req(store_if.i_wd_data);
            s2_vld_q <= s1_vld_q;
            s2_req_q <= s1_req_q;
            if (s2_vld_q && s2_req_q.cmd == TOHOST_CMD_POWEROFF) poweroff_q <= 1'b1;
            if (fifo_drop) overflow_q <= 1'b1;
        end
    end

    assign push_vld = s2_vld_q && (s2_req_q.cmd == TOHOST_CMD_PRINT);

    console_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .w_clk      (w_clk),
        .r_rst      (r_rst),
        .push_vld_i (push_vld),
        .push_dat_i (s2_req_q.chr),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .count_o    (fifo_count),
        .drop_o     (fifo_drop)
    );

    assign period_done = (cnt_q == '0);

    always_ff @(posedge w_clk) begin
        if (r_rst) state_q <= TX_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:  if (fifo_count != '0)                state_d = TX_START;
            TX_START: if (period_done)                     state_d = TX_DATA;
            TX_DATA:  if (period_done && bit_q == 3'd7)    state_d = TX_STOP;
            TX_STOP:  if (period_done)                     state_d = TX_IDLE;
            default:                                       state_d = TX_IDLE;
        endcase
    end

    // txd_d is the line level for the next cycle, so each transition loads the first level of the new phase.
    always_comb begin
        pop     = 1'b0;
        cnt_d   = period_done ? CNT_RELOAD : cnt_q - CNTW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        case (state_q)
            TX_IDLE: begin
                cnt_d = CNT_RELOAD;
                pop   = (fifo_count != '0);
                txd_d = ~pop;
                if (pop) shift_d = head_dat;
            end
            TX_START: begin
                if (period_done) begin
                    bit_d = 3'd0;
                    txd_d = shift_q[0];
                end
            end
            TX_DATA: begin
                if (period_done) begin
                    if (bit_q == 3'd7) begin
                        txd_d = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shift_q[bit_q + 3'd1];
                    end
                end
            end
            TX_STOP: begin
                txd_d = 1'b1;
            end
            default: begin
                txd_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (r_rst) begin
            cnt_q   <= CNT_RELOAD;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign o_txd      = txd_q;
    assign o_poweroff = poweroff_q;
    assign o_overflow = overflow_q;
    assign o_count    = fifo_count;
    assign o_busy     = (fifo_count != '0) || (state_q != TX_IDLE);

endmodule

// File: tb/tb_tohost_console.sv
// Directed bench for tohost_console: queue-level model checked every cycle plus literal timing pins.
module tb_tohost_console;

    localparam logic [31:0] TH = 32'h40008000;
    localparam int D = 4;
    localparam int W = 4;

    typedef struct packed {
        logic       vld;
        logic [1:0] cmd;
        logic [7:0] ch;
    } mev_t;

    logic       w_clk = 1'b0;
    logic       r_rst = 1'b1;
    logic       o_txd, o_poweroff, o_busy, o_overflow;
    logic [2:0] o_count;

    tohost_console_if bus();

    tohost_console #(.TOHOST_ADDR(TH), .QUEUE_DEPTH(D), .SERIAL_WCNT(W)) dut (
        .w_clk      (w_clk),
        .r_rst      (r_rst),
        .store_if   (bus),
        .o_txd      (o_txd),
        .o_poweroff (o_poweroff),
        .o_busy     (o_busy),
        .o_overflow (o_overflow),
        .o_count    (o_count)
    );

    always #5 w_clk = ~w_clk;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int base = 0;

    always @(posedge w_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            if (errs <= 40)
                $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, got, exp, cyc - base);
        end
    endtask

    // ---------------- behavioural model: queue of chars + frame position ----------------
    bit        m_on = 0;
    byte       m_q[$];
    bit        m_pw, m_ov, m_fa;
    int        m_pos;
    logic [7:0] m_ch;
    mev_t      ev_d1, ev_d2, act;

    function automatic logic frame_bit(input logic [7:0] ch, input int pos);
        int k;
        k = pos / W;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return ch[k-1];
    endfunction

    always @(negedge w_clk) begin
        bit pop;
        if (m_on) begin
            chk("txd",      o_txd,      m_fa ? frame_bit(m_ch, m_pos) : 1'b1);
            chk("count",    o_count,    m_q.size());
            chk("busy",     o_busy,     (m_q.size() != 0) || m_fa);
            chk("poweroff", o_poweroff, m_pw);
            chk("overflow", o_overflow, m_ov);
        end
        if (r_rst) begin
            m_on = 1; m_q.delete(); m_pw = 0; m_ov = 0; m_fa = 0; m_pos = 0;
            ev_d1 = '0; ev_d2 = '0;
        end else if (m_on) begin
            act = ev_d2;
            ev_d2 = ev_d1;
            ev_d1.vld = (bus.i_d_addr == TH) && bus.i_d_we[0];
            ev_d1.cmd = bus.i_wd_data[17:16];
            ev_d1.ch  = bus.i_wd_data[7:0];
            pop = !m_fa && (m_q.size() > 0);
            if (m_fa) begin
                m_pos++;
                if (m_pos == 10 * W) m_fa = 0;
            end
            if (pop) begin
                m_ch = m_q.pop_front(); m_fa = 1; m_pos = 0;
            end
            if (act.vld && act.cmd == 2'd1) begin
                if (m_q.size() < D) m_q.push_back(act.ch);
                else m_ov = 1;
            end
            if (act.vld && act.cmd == 2'd2) m_pw = 1;
        end
    end

    // ---------------- UART receiver on o_txd ----------------
    logic [7:0] rx_q[$];
    int  rx_frames = 0;
    bit  rx_busy = 0;
    int  rx_cnt;
    logic [7:0] rx_sh;
    logic prev_txd = 1'b1;

    always @(negedge w_clk) begin
        if (r_rst) begin
            rx_busy = 0;
        end else if (!rx_busy) begin
            if (prev_txd === 1'b1 && o_txd === 1'b0) begin
                rx_busy = 1; rx_cnt = 0; rx_frames++;
            end
        end else begin
            rx_cnt++;
            for (int i = 0; i < 8; i++)
                if (rx_cnt == W * (i + 1) + W / 2) rx_sh[i] = o_txd;
            if (rx_cnt == 9 * W + W / 2) rx_q.push_back(rx_sh);
            if (rx_cnt == 10 * W - 1) rx_busy = 0;
        end
        prev_txd = o_txd;
    end

    // ---------------- stimulus helpers ----------------
    task automatic put(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        bus.i_d_addr = a; bus.i_d_we = we; bus.i_wd_data = d;
    endtask

    task automatic idle_bus();
        put(32'h0, 4'b0000, 32'h0);
    endtask

    task automatic start_seq();
        @(posedge w_clk); #1;
        base = cyc;
    endtask

    task automatic wait_pos(input int k);
        while (cyc < base + k) begin
            @(posedge w_clk); #1;
        end
    endtask

    task automatic at(input int k);
        @(negedge w_clk);
        while (cyc < base + k) @(negedge w_clk);
    endtask

    task automatic do_reset();
        @(posedge w_clk); #1; r_rst = 1'b1;
        @(posedge w_clk); #1; r_rst = 1'b0;
    endtask

    task automatic drain(input string nm, input int lim);
        int n;
        n = 0;
        @(negedge w_clk);
        while (o_busy && n < lim) begin
            @(negedge w_clk);
            n++;
        end
        chk(nm, o_busy, 1'b0);
    endtask

    logic exp_b41[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int fr;
        idle_bus();
        r_rst = 1'b1;
        repeat (3) @(posedge w_clk);
        #1 r_rst = 1'b0;

        // 1: single 'A' frame timing
        start_seq();
        put(TH, 4'b0001, 32'h00010041);
        wait_pos(1); idle_bus();
        at(3); chk("t1_count_c3", o_count, 1);
        for (int k = 4; k < 8; k++) begin at(k); chk("t1_start", o_txd, 1'b0); end
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < W; j++) begin
                at(8 + W * i + j); chk("t1_data", o_txd, exp_b41[i]);
            end
        for (int k = 40; k < 44; k++) begin at(k); chk("t1_stop", o_txd, 1'b1); end
        chk("t1_busy_c43", o_busy, 1'b1);
        at(44); chk("t1_busy_c44", o_busy, 1'b0);
        chk("t1_rx_n", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("t1_rx_char", rx_q[0], 8'h41);
        rx_q.delete();

        // 2: six prints back to back into a 4-deep FIFO
        start_seq();
        for (int i = 0; i < 6; i++) begin
            wait_pos(i); put(TH, 4'b0001, 32'h00010031 + 32'(i));
        end
        wait_pos(6); idle_bus();
        at(7); chk("t2_count_full", o_count, 4); chk("t2_ovf_c7", o_overflow, 1'b0);
        at(8); chk("t2_ovf_c8", o_overflow, 1'b1);
        drain("t2_drain", 600);
        chk("t2_rx_n", rx_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < rx_q.size()) chk("t2_rx_char", rx_q[i], 8'h31 + 8'(i));
        rx_q.delete();
        do_reset();

        // 3: poweroff
        start_seq();
        put(TH, 4'b0001, 32'h00020000);
        wait_pos(1); idle_bus();
        at(2); chk("t3_pw_c2", o_poweroff, 1'b0);
        at(3); chk("t3_pw_c3", o_poweroff, 1'b1);
        at(30); chk("t3_pw_c30", o_poweroff, 1'b1); chk("t3_txd", o_txd, 1'b1);

        // 4: stores that must be ignored
        start_seq();
        put(TH + 32'd4, 4'b0001, 32'h00010041);
        wait_pos(1); put(TH, 4'b0010, 32'h00010041);
        wait_pos(2); put(TH, 4'b0001, 32'h00030041);
        wait_pos(3); idle_bus();
        for (int k = 3; k < 8; k++) begin
            at(k); chk("t4_count", o_count, 0); chk("t4_txd", o_txd, 1'b1);
        end
        at(60); chk("t4_rx_n", rx_q.size(), 0);
        do_reset();

        // 5: reset during DATA with two characters queued
        start_seq();
        for (int i = 0; i < 3; i++) begin
            wait_pos(i); put(TH, 4'b0001, 32'h00010051 + 32'(i));
        end
        wait_pos(3); idle_bus();
        wait_pos(10); r_rst = 1'b1;
        at(10); chk("t5_count_pre", o_count, 2);
        wait_pos(11); r_rst = 1'b0;
        at(11); chk("t5_txd", o_txd, 1'b1); chk("t5_count", o_count, 0); chk("t5_busy", o_busy, 1'b0);
        fr = rx_frames;
        at(160); chk("t5_no_frames", rx_frames - fr, 0); chk("t5_rx_n", rx_q.size(), 0);

        // 6: full FIFO with push and pop in the same cycle
        start_seq();
        for (int i = 0; i < 5; i++) begin
            wait_pos(i); put(TH, 4'b0001, 32'h00010061 + 32'(i));
        end
        wait_pos(5); idle_bus();
        at(7); chk("t6_count_c7", o_count, 4);
        wait_pos(42); put(TH, 4'b0001, 32'h00010066);
        wait_pos(43); idle_bus();
        at(44); chk("t6_count_c44", o_count, 4);
        at(45); chk("t6_count_c45", o_count, 4); chk("t6_ovf", o_overflow, 1'b0);
        drain("t6_drain", 800);
        chk("t6_rx_n", rx_q.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < rx_q.size()) chk("t6_rx_char", rx_q[i], 8'h61 + 8'(i));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
